dispense_controller: RTL and testbench

Responder/initiator counterpart to the vending selection state machine. It reports per-slot stock on `fullInventory`, answers the cancel request (`cancelled` → `cancelledDone`), and after a product is dispensed raises the `changeState` request that returns the selector to product selection. It owns the slot inventory counters, the dispense motor pulse and the refund pulse. It sits between the selection FSM and the vending hardware drivers.

---
 rtl/dispense_controller_if.sv | 32 +++
 rtl/dispense_controller.sv | 172 +++++++++++++++++
 tb/tb_dispense_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispense_controller_if.sv
// Selector <-> dispense controller signal bundle; salesCount exists only
// when DISPENSE_SALES_COUNT_EN is defined.
interface dispense_controller_if;
   logic [1:0] state;
   logic [3:0] index;
   logic       cancelled;
   logic       changeStateDone;
   logic       restock;
   logic       fullInventory;
   logic       cancelledDone;
   logic       changeState;
   logic       dispense;
   logic       refund;
   logic       dispenseFault;
`ifdef DISPENSE_SALES_COUNT_EN
   logic [15:0] salesCount;

   modport master (output state, index, cancelled, changeStateDone, restock,
                   input  fullInventory, cancelledDone, changeState, dispense,
                          refund, dispenseFault, salesCount);
   modport slave  (input  state, index, cancelled, changeStateDone, restock,
                   output fullInventory, cancelledDone, changeState, dispense,
                          refund, dispenseFault, salesCount);
`else
   modport master (output state, index, cancelled, changeStateDone, restock,
                   input  fullInventory, cancelledDone, changeState, dispense,
                          refund, dispenseFault);
   modport slave  (input  state, index, cancelled, changeStateDone, restock,
                   output fullInventory, cancelledDone, changeState, dispense,
                          refund, dispenseFault);
`endif
endinterface

// File: rtl/dispense_controller.sv
// Vending dispense controller: slot inventory, motor/refund pulses and the
// cancel / changeState handshakes. Optional sales counter: DISPENSE_SALES_COUNT_EN.
module dispense_slot #(
   parameter int CNT_W      = 4,
   parameter int INIT_COUNT = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   output logic [CNT_W-1:0] count
);
   // Restock beats a same-cycle decrement; an empty slot never wraps.
   always_ff @(posedge clk) begin
      if (rst || load)                count <= CNT_W'(INIT_COUNT);
      else if (dec && count != '0)    count <= count - 1'b1;
   end
endmodule

module dispense_controller #(
   parameter int NUM_SLOTS       = 16,
   parameter int CNT_W           = 4,
   parameter int INIT_COUNT      = 5,
   parameter int DISPENSE_CYCLES = 8,
   parameter int REFUND_CYCLES   = 4
) (
   input logic                  clk,
   input logic                  rst,
   dispense_controller_if.slave bus
);
   localparam int MAXC = (DISPENSE_CYCLES > REFUND_CYCLES) ? DISPENSE_CYCLES : REFUND_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, DISPENSE, REQ, RELEASE, REFUND, ACK} st_t;

   st_t                          st_q, st_d;
   logic [TW-1:0]                tmr_q, tmr_d;
   logic [3:0]                   slot_q, slot_d;
   logic                         armed_q, armed_d;
   logic                         dsp_q, dsp_d, rfd_q, rfd_d, cs_q, cs_d, cd_q, cd_d, flt_q, flt_d;
   logic                         dec_en;
   logic [NUM_SLOTS-1:0][CNT_W-1:0] count;
   logic [15:0]                  nonempty;

   // Index space is padded to 16 so out-of-range slots simply read empty.
   for (genvar g = 0; g < 16; g++) begin : g_slot
      if (g < NUM_SLOTS) begin : g_on
         dispense_slot #(.CNT_W(CNT_W), .INIT_COUNT(INIT_COUNT)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (bus.restock && bus.index == 4'(g)),
            .dec   (dec_en && slot_d == 4'(g)),
            .count (count[g])
         );
         assign nonempty[g] = |count[g];
      end else begin : g_off
         assign nonempty[g] = 1'b0;
      end
   end

   always_comb begin
      st_d    = st_q;
      tmr_d   = tmr_q;
      slot_d  = slot_q;
      armed_d = armed_q | (bus.state != 2'b01);
      dsp_d   = dsp_q;
      rfd_d   = rfd_q;
      cs_d    = cs_q;
      cd_d    = cd_q;
      flt_d   = 1'b0;
      dec_en  = 1'b0;
      unique case (st_q)
         IDLE: begin
            if (bus.cancelled && !cd_q) begin
               st_d  = REFUND;
               rfd_d = 1'b1;
               tmr_d = '0;
            end else if (bus.state == 2'b01 && armed_q) begin
               armed_d = 1'b0;
               slot_d  = bus.index;
               if (nonempty[slot_d]) begin
                  dec_en = 1'b1;
                  dsp_d  = 1'b1;
                  tmr_d  = '0;
                  st_d   = DISPENSE;
               end else begin
                  // Empty slot: flag it but still release the selector.
                  flt_d = 1'b1;
                  st_d  = REQ;
               end
            end
         end
         DISPENSE: begin
            if (tmr_q == TW'(DISPENSE_CYCLES - 1)) begin
               dsp_d = 1'b0;
               st_d  = REQ;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         REQ: begin
            if (bus.changeStateDone) begin
               cs_d = 1'b0;
               st_d = RELEASE;
            end else begin
               cs_d = 1'b1;
            end
         end
         RELEASE: if (!bus.changeStateDone) st_d = IDLE;
         REFUND: begin
            if (tmr_q == TW'(REFUND_CYCLES - 1)) begin
               rfd_d = 1'b0;
               st_d  = ACK;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         ACK: begin
            if (!cd_q) begin
               cd_d = 1'b1;
            end else if (!bus.cancelled) begin
               cd_d = 1'b0;
               st_d = IDLE;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         tmr_q   <= '0;
         slot_q  <= '0;
         armed_q <= 1'b1;
         dsp_q   <= 1'b0;
         rfd_q   <= 1'b0;
         cs_q    <= 1'b0;
         cd_q    <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         tmr_q   <= tmr_d;
         slot_q  <= slot_d;
         armed_q <= armed_d;
         dsp_q   <= dsp_d;
         rfd_q   <= rfd_d;
         cs_q    <= cs_d;
         cd_q    <= cd_d;
         flt_q   <= flt_d;
      end
   end

   assign bus.fullInventory = nonempty[bus.index];
   assign bus.dispense      = dsp_q;
   assign bus.refund        = rfd_q;
   assign bus.changeState   = cs_q;
   assign bus.cancelledDone = cd_q;
   assign bus.dispenseFault = flt_q;

`ifdef DISPENSE_SALES_COUNT_EN
   logic [15:0] sales_q;

   // Only completed motor runs count; the fault path bypasses DISPENSE.
   always_ff @(posedge clk) begin
      if (rst)                                sales_q <= '0;
      else if (st_q == DISPENSE && st_d == REQ) sales_q <= sales_q + 16'd1;
   end

   assign bus.salesCount = sales_q;
`endif
endmodule

// File: tb/tb_dispense_controller.sv
// Bench for dispense_controller: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_dispense_controller;
   localparam int D    = 8;
   localparam int R    = 4;
   localparam int INIT = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dispense_controller_if bus();

   dispense_controller #(
      .NUM_SLOTS(16), .CNT_W(4), .INIT_COUNT(INIT),
      .DISPENSE_CYCLES(D), .REFUND_CYCLES(R)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int n_disp = 0, n_ref = 0, n_flt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a transaction is a start edge plus the edges at which the
   // selector answered; outputs follow from edge distances to those points.
   int m_cnt[16];
   bit m_armed = 1'b1, m_busy = 1'b0;
   int m_kind = 0;          // 1 good dispense, 2 empty-slot fault, 3 cancel
   int m_t0 = 0, m_cs_start = 0, m_ack = -1, m_n = 0, m_sales = 0;

   task automatic model_step();
      m_n++;
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = INIT;
         m_armed = 1'b1;
         m_busy  = 1'b0;
         m_sales = 0;
         return;
      end
      if (bus.state != 2'b01) m_armed = 1'b1;
      if (m_busy) begin
         if (m_kind == 3) begin
            if (m_n >= m_t0 + R + 2 && !bus.cancelled) m_busy = 1'b0;
         end else if (m_n >= m_cs_start && m_ack < 0 && bus.changeStateDone) begin
            m_ack = m_n;
         end else if (m_ack >= 0 && m_n > m_ack && !bus.changeStateDone) begin
            m_busy = 1'b0;
         end
         if (m_kind == 1 && m_n == m_t0 + D) m_sales = (m_sales + 1) % 65536;
      end else if (bus.cancelled) begin
         m_busy = 1'b1; m_kind = 3; m_t0 = m_n;
      end else if (bus.state == 2'b01 && m_armed) begin
         m_armed = 1'b0; m_busy = 1'b1; m_t0 = m_n; m_ack = -1;
         if (m_cnt[bus.index] != 0) begin
            m_kind = 1; m_cnt[bus.index]--; m_cs_start = m_n + D + 1;
         end else begin
            m_kind = 2; m_cs_start = m_n + 1;
         end
      end
      if (bus.restock) m_cnt[bus.index] = INIT;
   endtask

   task automatic compare();
      int dt;
      dt = m_n - m_t0;
      chk("dispense",      bus.dispense,      m_busy && m_kind == 1 && dt < D);
      chk("refund",        bus.refund,        m_busy && m_kind == 3 && dt < R);
      chk("changeState",   bus.changeState,   m_busy && m_kind != 3 && m_n >= m_cs_start && m_ack < 0);
      chk("cancelledDone", bus.cancelledDone, m_busy && m_kind == 3 && dt >= R + 1);
      chk("dispenseFault", bus.dispenseFault, m_busy && m_kind == 2 && dt == 0);
      chk("fullInventory", bus.fullInventory, m_cnt[bus.index] != 0);
`ifdef DISPENSE_SALES_COUNT_EN
      chk("salesCount",    bus.salesCount,    m_sales);
`endif
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         compare();
      end
   end

   task automatic step();
      @(negedge clk);
      n_disp += int'(bus.dispense);
      n_ref  += int'(bus.refund);
      n_flt  += int'(bus.dispenseFault);
   endtask

   task automatic wait_sig(input string nm, input bit sel_cs, input logic val, input int lim);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < lim && !hit; i++) begin
         step();
         hit = ((sel_cs ? bus.changeState : bus.cancelledDone) === val);
      end
      chk(nm, hit, 1);
   endtask

   task automatic finish_hs(input bit hold);
      wait_sig("cs_rise", 1'b1, 1'b1, 40);
      if (!hold) bus.state = 2'b00;
      bus.changeStateDone = 1'b1;
      wait_sig("cs_fall", 1'b1, 1'b0, 5);
      bus.changeStateDone = 1'b0;
      step();
   endtask

   task automatic dispense_txn(input logic [3:0] idx, input bit hold);
      bus.index = idx;
      bus.state = 2'b01;
      finish_hs(hold);
   endtask

   initial begin
      bus.state = 2'b00; bus.index = 4'd0; bus.cancelled = 1'b0;
      bus.changeStateDone = 1'b0; bus.restock = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_dispense", bus.dispense, 0);
      chk("rst_cs", bus.changeState, 0);

      // Basic dispense on slot 3, selector keeps state at 01 afterwards.
      bus.index = 4'd3; #1;
      chk("fi_slot3", bus.fullInventory, 1);
      n_disp = 0;
      dispense_txn(4'd3, 1'b1);
      chk("disp_cycles", n_disp, 8);
      chk("model_cnt3", m_cnt[3], 4);
      n_disp = 0;
      repeat (20) step();
      chk("no_redispense", n_disp, 0);
      bus.state = 2'b00;
      step();

      // Drain slot 2, then request once more on the empty slot.
      rst = 1'b1; step(); rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         dispense_txn(4'd2, 1'b0);
         step();
`ifdef DISPENSE_SALES_COUNT_EN
         if (k == 2) chk("sales3", bus.salesCount, 3);
`endif
      end
      #1;
      chk("fi_slot2_empty", bus.fullInventory, 0);
      chk("model_cnt2", m_cnt[2], 0);
      n_disp = 0; n_flt = 0;
      dispense_txn(4'd2, 1'b0);
      chk("fault_pulse", n_flt, 1);
      chk("fault_no_disp", n_disp, 0);
`ifdef DISPENSE_SALES_COUNT_EN
      chk("sales_after_fault", bus.salesCount, 5);
`endif

      // Cancel from IDLE.
      n_ref = 0;
      bus.cancelled = 1'b1;
      wait_sig("cd_rise", 1'b0, 1'b1, 20);
      chk("refund_cycles", n_ref, 4);
      bus.cancelled = 1'b0;
      step();
      chk("cd_fall", bus.cancelledDone, 0);

      // Cancel and dispense request in the same cycle: cancel wins.
      n_ref = 0; n_disp = 0;
      bus.index = 4'd4; bus.state = 2'b01; bus.cancelled = 1'b1;
      wait_sig("cd_rise_both", 1'b0, 1'b1, 20);
      bus.state = 2'b00; bus.cancelled = 1'b0;
      step();
      chk("both_no_disp", n_disp, 0);
      chk("both_refund", n_ref, 4);
      chk("model_cnt4", m_cnt[4], 5);

      // Cancel raised mid-dispense waits for the handshake to finish.
      n_ref = 0;
      bus.index = 4'd5; bus.state = 2'b01;
      repeat (3) step();
      bus.cancelled = 1'b1;
      finish_hs(1'b0);
      chk("no_refund_in_txn", n_ref, 0);
      wait_sig("cd_rise_late", 1'b0, 1'b1, 20);
      chk("refund_cycles_late", n_ref, 4);
      bus.cancelled = 1'b0;
      repeat (2) step();

      // Restock empty slot 2 while slot 6 dispenses.
      bus.index = 4'd6; bus.state = 2'b01;
      repeat (2) step();
      bus.index = 4'd2; bus.restock = 1'b1;
      step();
      bus.restock = 1'b0; bus.index = 4'd6;
      finish_hs(1'b0);
      chk("model_cnt2_restock", m_cnt[2], 5);
      chk("model_cnt6", m_cnt[6], 4);
      bus.index = 4'd2; #1;
      chk("fi_slot2_restock", bus.fullInventory, 1);

      // Restock and decrement on the same slot in the same edge.
      bus.index = 4'd7; bus.state = 2'b01; bus.restock = 1'b1;
      step();
      bus.restock = 1'b0;
      finish_hs(1'b0);
      chk("model_cnt7", m_cnt[7], 5);

      // Reset while changeState is up.
      bus.index = 4'd8; bus.state = 2'b01;
      wait_sig("cs_rise_rst", 1'b1, 1'b1, 40);
      rst = 1'b1;
      step();
      chk("cs_after_rst", bus.changeState, 0);
      rst = 1'b0; bus.state = 2'b00;
      for (int i = 0; i < 16; i++) begin
         bus.index = 4'(i);
         step();
         chk("fi_after_rst", bus.fullInventory, 1);
      end

      // Random selector traffic.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0, 1:    bus.state = 2'b01;
               2:       bus.state = 2'b00;
               default: bus.state = 2'b11;
            endcase
         end
         if ($urandom_range(0, 3) == 0)
            bus.index = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) bus.cancelled = ~bus.cancelled;
         if (bus.changeState) begin
            if ($urandom_range(0, 2) != 0) bus.changeStateDone = 1'b1;
         end else if ($urandom_range(0, 2) != 0) begin
            bus.changeStateDone = 1'b0;
         end
         bus.restock = ($urandom_range(0, 39) == 0);
         step();
      end
      rst = 1'b0; bus.restock = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
